// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence memory game: state codes, default
// parameters and the content rule of the sequence ROM.
package jogo_pkg;

    localparam int unsigned N_CHAVES_PADRAO       = 4;
    localparam int unsigned PROFUNDIDADE_PADRAO   = 16;
    localparam int unsigned TIMEOUT_CICLOS_PADRAO = 5000;
    localparam int unsigned N_CHAVES_MAX          = 8;
    localparam int unsigned ESTADO_W              = 4;

    // Codes are visible on db_estado; final states keep fixed, readable values.
    typedef enum logic [ESTADO_W-1:0] {
        StInicial       = 4'h0,
        StPrepara       = 4'h1,
        StIniciaRodada  = 4'h2,
        StEspera        = 4'h3,
        StRegistra      = 4'h4,
        StCompara       = 4'h5,
        StProxima       = 4'h6,
        StProximaRodada = 4'h7,
        StFimAcerto     = 4'hA,
        StFimErro       = 4'hE,
        StFimTimeout    = 4'hF
    } estado_t;

    function automatic logic [N_CHAVES_MAX-1:0] palavra_rom(input int unsigned indice,
                                                           input int unsigned n_chaves);
        logic [N_CHAVES_MAX-1:0] palavra;
        palavra = N_CHAVES_MAX'(1) << (indice % n_chaves);
        return palavra;
    endfunction

endpackage

// File: rtl/rom_sequencia.sv
// Synchronous-read ROM holding the expected key for each move index.
module rom_sequencia
    import jogo_pkg::*;
#(
    parameter int unsigned N_CHAVES     = N_CHAVES_PADRAO,
    parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                            clock,
    input  logic [$clog2(PROFUNDIDADE)-1:0] endereco,
    output logic [N_CHAVES-1:0]             dado
);

    logic [N_CHAVES_MAX-1:0] palavra;

    always_comb begin
        palavra = palavra_rom(32'(endereco), N_CHAVES);
    end

    always_ff @(posedge clock) begin
        dado <= N_CHAVES'(palavra);
    end

endmodule

// File: rtl/jogo_sequencia_param.sv
// Sequence memory game: each round the player repeats the ROM sequence up to
// the current round, with a per-move timeout.
module jogo_sequencia_param
    import jogo_pkg::*;
#(
    parameter int unsigned N_CHAVES       = N_CHAVES_PADRAO,
    parameter int unsigned PROFUNDIDADE   = PROFUNDIDADE_PADRAO,
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            iniciar,
    input  logic                            modo,
    input  logic [N_CHAVES-1:0]             chaves,
    output logic [N_CHAVES-1:0]             leds,
    output logic                            pronto,
    output logic                            ganhou,
    output logic                            perdeu,
    output logic                            db_timeout,
    output logic [3:0]                      db_estado,
    output logic [$clog2(PROFUNDIDADE)-1:0] db_rodada,
    output logic [$clog2(PROFUNDIDADE)-1:0] db_endereco
);

    localparam int unsigned AW = $clog2(PROFUNDIDADE);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CICLOS);

    localparam logic [TW-1:0] TIMEOUT_FIM  = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [LW-1:0] LIMITE_CHEIO = LW'(PROFUNDIDADE);
    localparam logic [LW-1:0] LIMITE_MEIO  = LW'(PROFUNDIDADE / 2);

    estado_t estado_q, estado_d;

    logic [N_CHAVES-1:0] chaves_q;
    logic [N_CHAVES-1:0] leds_q;
    logic [N_CHAVES-1:0] rom_dado;
    logic [AW-1:0]       rodada_q;
    logic [AW-1:0]       endereco_q;
    logic [LW-1:0]       limite_q;
    logic [TW-1:0]       timeout_q;

    logic limpa_rodada, inc_rodada;
    logic limpa_endereco, inc_endereco;
    logic limpa_timeout, conta_timeout;
    logic limpa_leds, registra_leds;
    logic captura_limite;

    logic jogada, fim_timeout, acerto, ultima_jogada, ultima_rodada;

    rom_sequencia #(
        .N_CHAVES     (N_CHAVES),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_rom (
        .clock    (clock),
        .endereco (endereco_q),
        .dado     (rom_dado)
    );

    // A move is an edge: keys idle last cycle and pressed now.
    assign jogada        = (chaves != '0) && (chaves_q == '0);
    assign fim_timeout   = (timeout_q == TIMEOUT_FIM);
    assign acerto        = (leds_q == rom_dado);
    assign ultima_jogada = (endereco_q == rodada_q);
    assign ultima_rodada = ({1'b0, rodada_q} == (limite_q - LW'(1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= StInicial;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d       = estado_q;
        limpa_rodada   = 1'b0;
        inc_rodada     = 1'b0;
        limpa_endereco = 1'b0;
        inc_endereco   = 1'b0;
        limpa_timeout  = 1'b0;
        conta_timeout  = 1'b0;
        limpa_leds     = 1'b0;
        registra_leds  = 1'b0;
        captura_limite = 1'b0;

        unique case (estado_q)
            StInicial: begin
                if (iniciar) estado_d = StPrepara;
            end
            StPrepara: begin
                limpa_rodada   = 1'b1;
                limpa_endereco = 1'b1;
                limpa_leds     = 1'b1;
                limpa_timeout  = 1'b1;
                captura_limite = 1'b1;
                estado_d       = StIniciaRodada;
            end
            StIniciaRodada: begin
                limpa_endereco = 1'b1;
                limpa_timeout  = 1'b1;
                estado_d       = StEspera;
            end
            StEspera: begin
                // A move on the last allowed cycle beats the timeout.
                if (jogada) begin
                    limpa_timeout = 1'b1;
                    estado_d      = StRegistra;
                end else if (fim_timeout) begin
                    estado_d = StFimTimeout;
                end else begin
                    conta_timeout = 1'b1;
                end
            end
            StRegistra: begin
                registra_leds = 1'b1;
                estado_d      = StCompara;
            end
            StCompara: begin
                if (!acerto) begin
                    estado_d = StFimErro;
                end else if (!ultima_jogada) begin
                    estado_d = StProxima;
                end else if (ultima_rodada) begin
                    estado_d = StFimAcerto;
                end else begin
                    estado_d = StProximaRodada;
                end
            end
            StProxima: begin
                inc_endereco = 1'b1;
                estado_d     = StEspera;
            end
            StProximaRodada: begin
                inc_rodada = 1'b1;
                estado_d   = StIniciaRodada;
            end
            StFimAcerto, StFimErro, StFimTimeout: begin
                if (iniciar) estado_d = StPrepara;
            end
            default: begin
                estado_d = StInicial;
            end
        endcase
    end

    // History is sampled in every state so keys held through reset or start
    // never look like a fresh press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chaves_q <= '0;
        end else begin
            chaves_q <= chaves;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            limite_q <= LIMITE_CHEIO;
        end else if (captura_limite) begin
            limite_q <= modo ? LIMITE_MEIO : LIMITE_CHEIO;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rodada_q <= '0;
        end else if (limpa_rodada) begin
            rodada_q <= '0;
        end else if (inc_rodada && !ultima_rodada) begin
            rodada_q <= rodada_q + AW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco_q <= '0;
        end else if (limpa_endereco) begin
            endereco_q <= '0;
        end else if (inc_endereco && !ultima_jogada) begin
            endereco_q <= endereco_q + AW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_q <= '0;
        end else if (limpa_timeout) begin
            timeout_q <= '0;
        end else if (conta_timeout && !fim_timeout) begin
            timeout_q <= timeout_q + TW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds_q <= '0;
        end else if (limpa_leds) begin
            leds_q <= '0;
        end else if (registra_leds) begin
            leds_q <= chaves;
        end
    end

    always_comb begin
        pronto     = (estado_q == StFimAcerto) || (estado_q == StFimErro) ||
                     (estado_q == StFimTimeout);
        ganhou     = (estado_q == StFimAcerto);
        perdeu     = (estado_q == StFimErro) || (estado_q == StFimTimeout);
        db_timeout = (estado_q == StFimTimeout);
    end

    assign leds        = leds_q;
    assign db_estado   = estado_q;
    assign db_rodada   = rodada_q;
    assign db_endereco = endereco_q;

endmodule

// File: doc/jogo_sequencia_param.md
JOGO_SEQUENCIA_PARAM -- requirements
Module: jogo_sequencia_param

Interface
REQ-001 Parameter N_CHAVES, default 4: number of player keys/LEDs; legal range 2..8.
REQ-002 Parameter PROFUNDIDADE, default 16: maximum rounds and memory depth; power of 2, 4..64.
REQ-003 Parameter TIMEOUT_CICLOS, default 5000: clock cycles allowed per move; legal minimum 4.
REQ-004 clock  in  1  sole clock, rising edge active.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 iniciar  in  1  level start request, sampled in INICIAL and in the final states.
REQ-007 modo  in  1  0 = PROFUNDIDADE rounds, 1 = PROFUNDIDADE/2 rounds; captured on game start.
REQ-008 chaves  in  N_CHAVES  player keys, one bit per key.
REQ-009 leds  out  N_CHAVES  last registered move.
REQ-010 pronto / ganhou / perdeu  out  1 each  game over / won / lost.
REQ-011 db_timeout  out  1  lost by timeout (subset of perdeu).
REQ-012 db_estado  out  4  current FSM state code.
REQ-013 db_rodada / db_endereco  out  clog2(PROFUNDIDADE) each  current round / move index.

Function
REQ-014 FSM states: INICIAL, PREPARA, INICIA_RODADA, ESPERA, REGISTRA, COMPARA, PROXIMA, PROXIMA_RODADA, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT.
REQ-015 INICIAL -> PREPARA when iniciar=1; PREPARA clears rodada, endereco, leds and timeout counter, and latches modo into limite, then -> INICIA_RODADA.
REQ-016 INICIA_RODADA clears endereco and timeout counter, then -> ESPERA.
REQ-017 A move is detected in ESPERA on a zero-to-nonzero transition of chaves, comparing against chaves registered on the previous cycle.
REQ-018 Holding chaves nonzero never produces a second move.
REQ-019 On the move, ESPERA -> REGISTRA; REGISTRA latches chaves into leds.
REQ-020 COMPARA checks leds against memory word at db_endereco, read through the synchronous ROM; any mismatch, including multiple bits set, -> FIM_ERRO.
REQ-021 On a match with endereco < rodada -> PROXIMA, which increments endereco and -> ESPERA.
REQ-022 On a match with endereco = rodada: if rodada = limite-1 -> FIM_ACERTO, else -> PROXIMA_RODADA, which increments rodada and -> INICIA_RODADA.
REQ-023 Result latency: perdeu or ganhou asserts on the 3rd rising edge after the first edge sampling the nonzero chaves.
REQ-024 Timeout counter runs only in ESPERA and clears on each detected move.
REQ-025 When the counter reaches TIMEOUT_CICLOS-1 with no move -> FIM_TIMEOUT; a move on that same cycle takes priority over the timeout.
REQ-026 In FIM_ACERTO: pronto=1, ganhou=1. In FIM_ERRO: pronto=1, perdeu=1. In FIM_TIMEOUT: pronto=1, perdeu=1, db_timeout=1.
REQ-027 Outputs stay held in each final state until iniciar=1, which -> PREPARA (restart with modo resampled).
REQ-028 limite = PROFUNDIDADE when modo=0, else PROFUNDIDADE/2.
REQ-029 Counters never wrap: rodada is bounded by limite-1 and endereco by rodada.
REQ-030 ROM word i = one-hot with bit (i mod N_CHAVES) set.
REQ-031 All outputs are registered or derived only from the state register; no combinational path from chaves to outputs.

Reset
REQ-032 reset=1 forces INICIAL immediately, in any state including mid-round or mid-timeout.
REQ-033 On reset, all outputs become 0: leds=0, pronto=ganhou=perdeu=db_timeout=0, db_rodada=db_endereco=0, db_estado = INICIAL code 0.
REQ-034 On reset, the chaves history register and timeout counter clear, so keys held through reset release do not count as a move.

Structure
REQ-035 Package jogo_pkg holds: state encodings (4-bit, INICIAL=0, FIM_ACERTO=0xA, FIM_ERRO=0xE, FIM_TIMEOUT=0xF), default parameter constants, and the ROM content function.
REQ-036 One sub-module, rom_sequencia: synchronous read, parametrised by N_CHAVES and PROFUNDIDADE; datapath counters stay inline.

Verification
REQ-037 Defaults, modo=0, reset then iniciar 5 cycles, all 136 correct moves 0001,0010,0100,1000 cyclic, 10 cycles each with 10-cycle gaps -> ganhou=1, pronto=1, db_rodada=15.
REQ-038 Round 4 (rodada=3), move 4 given 0001 instead of 1000 -> perdeu=1, db_timeout=0, db_estado=0xE, 3 edges after press.
REQ-039 modo=1, correct play -> ganhou after round rodada=7 (36 moves); then iniciar with modo=0 -> full 16-round game restarts from rodada=0.
REQ-040 TIMEOUT_CICLOS=20, no move after iniciar -> db_timeout=1, perdeu=1 exactly 20 cycles after entering ESPERA; a move on cycle 19 -> no timeout.
REQ-041 chaves=0011 on the first move -> perdeu; chaves held at 0001 for 50 cycles -> counted as one move only.
REQ-042 reset pulse mid-round 3 while a key is held -> outputs 0, state INICIAL; held key ignored after the next iniciar.
